// File: rtl/instr_prefetch_pkg.sv
// Shared fetch definitions: instruction width, NOP encoding and the control-transfer
// opcodes that the execute core also decodes.
package instr_prefetch_pkg;

  localparam int ILEN = 32;

  typedef logic [ILEN-1:0] instr_t;

  localparam instr_t     NOP_WORD  = 32'h0000_0013;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Width of the ROM word-address port, independent of the PC width.
  localparam int ROM_ADDR_W = 8;

  // True when the word can redirect the fetch stream.
  function automatic logic is_ctrl_xfer(input instr_t ir);
    return (ir[6:0] == OP_BRANCH) || (ir[6:0] == OP_JAL) || (ir[6:0] == OP_JALR);
  endfunction

  function automatic logic is_nop(input instr_t ir);
    return ir == NOP_WORD;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, ir} pairs for the prefetch stage.
// Flush clears occupancy and pointers; the head is always storage[rd_ptr].
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [W-1:0]  mem [DEPTH];
  logic          pop_ok;

  assign pop_ok = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Pointers, occupancy and storage; flush wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push) count <= count - 1'b1;
    end
  end

  // The issuing side reserves a slot before every read, so a push into a full FIFO is a bug.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && (count == (PW+1)'(DEPTH))));

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: issues ROM word reads ahead of the core, buffers
// {pc, ir} in fetch_fifo and presents the head with a valid/ready handshake.
// A redirect flushes the buffer, drops any response in that cycle and issues the
// target read in the same cycle.
// Optional: define IFETCH_PERF_EN to add the saturating stall/flush counters.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int             DEPTH    = 4,
  parameter int             AW       = 8,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  output logic                  oROM_CE,
  output logic                  oROM_RD,
  output logic [ROM_ADDR_W-1:0] oROM_ADDR,
  input  logic [ILEN-1:0]       iROM_DATA,
  input  logic                  iREDIRECT,
  input  logic [AW-1:0]         iREDIRECT_PC,
  output logic                  oIR_VALID,
  input  logic                  iIR_READY,
  output logic [ILEN-1:0]       oIR,
  output logic [AW-1:0]         oIR_PC
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]           oSTALL_CNT,
  output logic [15:0]           oFLUSH_CNT
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]      fpc;
  logic [AW-1:0]      pend_pc;
  logic [AW-1:0]      redir_pc;
  logic [AW-1:0]      issue_pc;
  logic [AW-1:0]      issue_word;
  logic               pend;
  logic               kill;
  logic               redir;
  logic               issue;
  logic               push;
  logic               pop;
  logic [CW-1:0]      count;
  logic [CW:0]        occ;
  logic [AW+ILEN-1:0] head;
  logic               unused_redir_lsb;

  assign unused_redir_lsb = ^iREDIRECT_PC[1:0];

  assign redir    = iREDIRECT && !iRST;
  assign redir_pc = {iREDIRECT_PC[AW-1:2], 2'b00};

  // Buffered plus in-flight words must leave room for the read being issued.
  assign occ   = {1'b0, count} + {{CW{1'b0}}, pend};
  assign issue = !iRST && (redir || (occ < (CW+1)'(DEPTH)));

  assign issue_pc   = redir ? redir_pc : fpc;
  assign issue_word = issue_pc >> 2;
  assign oROM_ADDR  = ROM_ADDR_W'(issue_word);
  assign oROM_CE    = issue;
  assign oROM_RD    = issue;

  // A response landing in a redirect cycle belongs to the abandoned stream.
  assign push = pend && !kill && !redir;
  assign pop  = oIR_VALID && iIR_READY && !redir;

  assign oIR_VALID = (count != '0);
  assign oIR       = head[ILEN-1:0];
  assign oIR_PC    = head[AW+ILEN-1:ILEN];

  // Fetch PC and in-flight read tracking.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      fpc     <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= '0;
      kill    <= 1'b0;
    end else begin
      pend <= issue;
      kill <= 1'b0;
      if (issue) begin
        pend_pc <= issue_pc;
        fpc     <= issue_pc + AW'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + ILEN)
  ) u_fifo (
    .clk   (iCLK),
    .rst   (iRST),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   ({pend_pc, iROM_DATA}),
    .count (count),
    .head  (head)
  );

`ifdef IFETCH_PERF_EN
  // Saturating counts of starved-core cycles and redirects.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oSTALL_CNT <= '0;
      oFLUSH_CNT <= '0;
    end else begin
      if (iIR_READY && !oIR_VALID && (oSTALL_CNT != 16'hFFFF)) oSTALL_CNT <= oSTALL_CNT + 1'b1;
      if (iREDIRECT && (oFLUSH_CNT != 16'hFFFF))                oFLUSH_CNT <= oFLUSH_CNT + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with a synchronous ROM model where ROM[i] = i+1.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_instr_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce, rom_rd;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redir;
  logic [7:0]  redir_pc;
  logic        ir_valid, ir_ready;
  logic [31:0] ir;
  logic [7:0]  ir_pc;
`ifdef IFETCH_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  logic [31:0] rom [256];
  int n_vec = 0;
  int n_bad = 0;
  int ce_n;

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_ce) rom_data <= rom[rom_addr];

  instr_prefetch dut (
    .iCLK         (clk),
    .iRST         (rst),
    .oROM_CE      (rom_ce),
    .oROM_RD      (rom_rd),
    .oROM_ADDR    (rom_addr),
    .iROM_DATA    (rom_data),
    .iREDIRECT    (redir),
    .iREDIRECT_PC (redir_pc),
    .oIR_VALID    (ir_valid),
    .iIR_READY    (ir_ready),
    .oIR          (ir),
    .oIR_PC       (ir_pc)
`ifdef IFETCH_PERF_EN
    ,
    .oSTALL_CNT   (stall_cnt),
    .oFLUSH_CNT   (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic rd, input logic [7:0] rpc);
    @(negedge clk);
    rst      = r;
    ir_ready = rdy;
    redir    = rd;
    redir_pc = rpc;
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [7:0] pc, input logic [31:0] w);
    check({tag, " valid"}, ir_valid, 1'b1);
    check({tag, " pc"}, ir_pc, pc);
    check({tag, " ir"}, ir, w);
  endtask

  task automatic chk_issue(input string tag, input logic [7:0] a);
    check({tag, " ce"}, rom_ce, 1'b1);
    check({tag, " rd"}, rom_rd, 1'b1);
    check({tag, " addr"}, rom_addr, a);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'(i + 1);
    rom_data = '0;
    rst = 1'b1; ir_ready = 1'b0; redir = 1'b0; redir_pc = '0;
    #2;
    check("rst valid", ir_valid, 1'b0);
    check("rst ir", ir, 32'h0);
    check("rst pc", ir_pc, 8'h00);
    check("rst ce", rom_ce, 1'b0);
    check("rst rd", rom_rd, 1'b0);
    check("rst addr", rom_addr, 8'h00);
    step(1, 1, 0, 0);

    // 1: streaming from reset
    step(0, 1, 0, 0);
    chk_issue("t1 r", 8'h00);
    check("t1 r valid", ir_valid, 1'b0);
    step(0, 1, 0, 0);
    check("t1 r+1 valid", ir_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0);
      chk_head("t1 seq", 8'(4 * k), 32'(k + 1));
    end

    // 2: core stalled for 10 cycles, exactly DEPTH reads issued
    step(1, 0, 0, 0);
    ce_n = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      ce_n += int'(rom_ce);
      if (i >= 2) chk_head("t2 hold", 8'h00, 32'h1);
    end
    check("t2 issues", ce_n, 4);
    check("t2 ce idle", rom_ce, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0);
      chk_head("t2 drain", 8'(4 * k), 32'(k + 1));
    end

    // 3: redirect with 3 buffered and one read in flight
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk_head("t3 pre", 8'h00, 32'h1);
    step(0, 0, 1, 8'h40);
    chk_issue("t3 t", 8'h10);
    step(0, 1, 0, 0);
    check("t3 t+1 valid", ir_valid, 1'b0);
    step(0, 1, 0, 0);
    chk_head("t3 t+2", 8'h40, 32'd17);
    step(0, 1, 0, 0);
    chk_head("t3 t+3", 8'h44, 32'd18);

    // 4: back-to-back redirects, second target wins
    step(0, 1, 1, 8'h20);
    chk_issue("t4 t", 8'h08);
    step(0, 1, 1, 8'h83);
    chk_issue("t4 t+1", 8'h20);
    check("t4 t+1 valid", ir_valid, 1'b0);
    step(0, 1, 0, 0);
    check("t4 t+2 valid", ir_valid, 1'b0);
    step(0, 1, 0, 0);
    chk_head("t4 t+3", 8'h80, 32'h21);
    step(0, 1, 0, 0);
    chk_head("t4 t+4", 8'h84, 32'h22);

    // 5: PC wrap at the top of the byte-address space
    step(0, 1, 1, 8'hF8);
    chk_issue("t5 a0", 8'h3E);
    step(0, 1, 0, 0);
    chk_issue("t5 a1", 8'h3F);
    step(0, 1, 0, 0);
    chk_issue("t5 a2", 8'h00);
    chk_head("t5 h0", 8'hF8, 32'h3F);
    step(0, 1, 0, 0);
    chk_head("t5 h1", 8'hFC, 32'h40);
    step(0, 1, 0, 0);
    chk_head("t5 h2", 8'h00, 32'h01);

    // 6: asynchronous reset mid-stream and restart
    step(1, 1, 0, 0);
    check("t6 rst valid", ir_valid, 1'b0);
    check("t6 rst ce", rom_ce, 1'b0);
    check("t6 rst addr", rom_addr, 8'h00);
`ifdef IFETCH_PERF_EN
    check("t6 rst stall", stall_cnt, 16'd0);
    check("t6 rst flush", flush_cnt, 16'd0);
`endif
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk_issue("t6 r", 8'h00);
    step(0, 1, 0, 0);
    check("t6 r+1 valid", ir_valid, 1'b0);
    step(0, 1, 0, 0);
    chk_head("t6 r+2", 8'h00, 32'h1);
`ifdef IFETCH_PERF_EN
    check("t6 stall", stall_cnt, 16'd2);
`endif
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'h10);
    step(0, 1, 0, 0);
`ifdef IFETCH_PERF_EN
    check("t6 flush", flush_cnt, 16'd3);
`endif
    check("t6 post-redir valid", ir_valid, 1'b0);
    step(0, 1, 0, 0);
    chk_head("t6 redir head", 8'h10, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
